// File: rtl/triage_sensor_cond_pkg.sv
// ----------------------------------------------------------------------------
// triage_sensor_cond_pkg
// Shared definitions for the triage sensor conditioning stage and triage_core:
// channel count, sensor bit positions within the S vector, default filter
// settings and the per-channel debounce state encoding.
// ----------------------------------------------------------------------------
package triage_sensor_cond_pkg;

    localparam int N_CH_DEF     = 6;
    localparam int DEB_CYC_DEF  = 4;
    localparam int DIV_DEF      = 1;
    localparam int CHAT_MAX_DEF = 8;

    // Bit positions of each patient sensor inside S (and RAW / FLT)
    localparam int IDX_HR   = 0;
    localparam int IDX_SPO2 = 1;
    localparam int IDX_BP   = 2;
    localparam int IDX_TEMP = 3;
    localparam int IDX_RESP = 4;
    localparam int IDX_FALL = 5;

    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } ch_state_t;

endpackage

// File: rtl/triage_sensor_cond_if.sv
// ----------------------------------------------------------------------------
// triage_sensor_cond_if
// Bundle of the sensor conditioning signals.
//   raw     : raw asynchronous sensor lines        (master -> slave)
//   flt_clr : synchronous clear of all fault flags (master -> slave)
//   s       : conditioned sensor vector            (slave -> master)
//   s_chg   : one-cycle pulse, s changed           (slave -> master)
//   flt     : sticky chatter fault per channel     (slave -> master)
// The conditioning block is the slave; its driver/consumer is the master.
// ----------------------------------------------------------------------------
interface triage_sensor_cond_if
    import triage_sensor_cond_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);
    logic [N_CH-1:0] raw;
    logic            flt_clr;
    logic [N_CH-1:0] s;
    logic            s_chg;
    logic [N_CH-1:0] flt;

    modport master (output raw, output flt_clr, input s, input s_chg, input flt);
    modport slave  (input raw, input flt_clr, output s, output s_chg, output flt);
endinterface

// File: rtl/triage_sensor_cond_debounce_ch.sv
// ----------------------------------------------------------------------------
// triage_debounce_ch
// One sensor channel: 2-FF synchroniser, persistence filter and chatter
// fault detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : sample enable from the shared prescaler
//   raw        : raw asynchronous sensor line
//   flt_clr    : clears the fault flag and chatter counter
//   s          : filtered level
//   flt        : sticky chatter fault
// ----------------------------------------------------------------------------
module triage_debounce_ch
    import triage_sensor_cond_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int CHAT_MAX = CHAT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    input  logic flt_clr,
    output logic s,
    output logic flt
);

    localparam int CNT_W  = $clog2(DEB_CYC + 1);
    localparam int CHAT_W = $clog2(CHAT_MAX + 1);

    logic              sy1, sy2;
    ch_state_t         state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [CHAT_W-1:0] chat_q, chat_n;
    logic              s_q, s_n;
    logic              flt_q, flt_n;
    logic              flt_set;

    function automatic logic [CHAT_W-1:0] chat_sat_inc(input logic [CHAT_W-1:0] c);
        return (c == CHAT_W'(CHAT_MAX)) ? c : c + 1'b1;
    endfunction

    // Synchroniser: only sy2 feeds the filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy1 <= 1'b0;
            sy2 <= 1'b0;
        end else begin
            sy1 <= raw;
            sy2 <= sy1;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_STABLE;
            cnt_q   <= '0;
            chat_q  <= '0;
            s_q     <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            chat_q  <= chat_n;
            s_q     <= s_n;
            flt_q   <= flt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        chat_n  = chat_q;
        s_n     = s_q;
        flt_set = 1'b0;

        if (tick) begin
            case (state_q)
                CH_STABLE: begin
                    cnt_n = '0;
                    if (sy2 != s_q) begin
                        if (DEB_CYC == 1) begin
                            // single-tick persistence: accept immediately
                            s_n    = sy2;
                            chat_n = '0;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = CH_PENDING;
                        end
                    end
                end
                CH_PENDING: begin
                    if (sy2 != s_q) begin
                        if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                            s_n     = sy2;
                            cnt_n   = '0;
                            chat_n  = '0;
                            state_n = CH_STABLE;
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end else begin
                        // level fell back before persisting: a rejected bounce
                        cnt_n   = '0;
                        chat_n  = chat_sat_inc(chat_q);
                        flt_set = (chat_n == CHAT_W'(CHAT_MAX));
                        state_n = CH_STABLE;
                    end
                end
                default: state_n = CH_STABLE;
            endcase
        end

        // A fault being raised this cycle takes precedence over the clear
        if (flt_clr && !flt_set) begin
            chat_n = '0;
        end
        flt_n = flt_set | (flt_q & ~flt_clr);
    end

    assign s   = s_q;
    assign flt = flt_q;

endmodule

// File: rtl/triage_sensor_cond.sv
// ----------------------------------------------------------------------------
// triage_sensor_cond
// Conditions N_CH raw, bouncy patient sensor lines into the registered
// sensor vector consumed by triage_core.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   sif   : slave side of triage_sensor_cond_if
//           (raw, flt_clr in; s, s_chg, flt out)
// Holds the shared sample prescaler, the change-strobe register and the
// per-channel filter instances.
// ----------------------------------------------------------------------------
module triage_sensor_cond
    import triage_sensor_cond_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int CHAT_MAX = CHAT_MAX_DEF
) (
    input logic                clk,
    input logic                rst_n,
    triage_sensor_cond_if.slave sif
);

    localparam int PRE_W = $clog2(DIV + 1);

    logic [PRE_W-1:0] pre_q;
    logic             tick;
    logic [N_CH-1:0]  s_vec;
    logic [N_CH-1:0]  flt_vec;
    logic [N_CH-1:0]  s_p1;
    logic             s_chg_q;

    // Sample prescaler: one tick per DIV clocks, first tick right after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (pre_q == PRE_W'(DIV - 1)) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign tick = (pre_q == '0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        triage_debounce_ch #(
            .DEB_CYC  (DEB_CYC),
            .CHAT_MAX (CHAT_MAX)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .raw     (sif.raw[i]),
            .flt_clr (sif.flt_clr),
            .s       (s_vec[i]),
            .flt     (flt_vec[i])
        );
    end

    // Change strobe: compares S with its previous value, so it rises the
    // cycle after the update and several bits changing together give one pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p1    <= '0;
            s_chg_q <= 1'b0;
        end else begin
            s_p1    <= s_vec;
            s_chg_q <= |(s_vec ^ s_p1);
        end
    end

    assign sif.s     = s_vec;
    assign sif.flt   = flt_vec;
    assign sif.s_chg = s_chg_q;

endmodule

// File: tb/tb_triage_sensor_cond.sv
// ----------------------------------------------------------------------------
// tb_triage_sensor_cond
// Two instances: default settings (A) and DIV=3, DEB_CYC=2 (B), both driven
// by the same stimulus. A run-length model of the filtering rules predicts
// S, S_CHG and FLT for each instance.
// ----------------------------------------------------------------------------
module tb_triage_sensor_cond;
    import triage_sensor_cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] raw = 6'h3F;
    logic       flt_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #50 clk = ~clk;

    triage_sensor_cond_if #(.N_CH(6)) ifa ();
    triage_sensor_cond_if #(.N_CH(6)) ifb ();

    assign ifa.raw     = raw;
    assign ifa.flt_clr = flt_clr;
    assign ifb.raw     = raw;
    assign ifb.flt_clr = flt_clr;

    triage_sensor_cond #(.N_CH(6), .DEB_CYC(4), .DIV(1), .CHAT_MAX(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (ifa.slave)
    );

    triage_sensor_cond #(.N_CH(6), .DEB_CYC(2), .DIV(3), .CHAT_MAX(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (ifb.slave)
    );

    // Model: per channel, the length of the current run of ticks on which
    // the synchronised input disagrees with S, and the number of runs that
    // ended without being accepted.
    typedef struct packed {
        logic [5:0]      sy1;
        logic [5:0]      sy2;
        logic [5:0]      s;
        logic [5:0]      flt;
        logic [5:0][7:0] run;
        logic [5:0][7:0] chat;
        logic [7:0]      pcnt;
        logic            chg_pend;
        logic            s_chg;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, logic [5:0] r, logic clr,
                                     int deb, int div, int cm);
        model_t n;
        logic   tick;
        logic   set;
        n    = m;
        tick = (m.pcnt == 8'd0);
        n.pcnt     = (int'(m.pcnt) + 1 >= div) ? 8'd0 : m.pcnt + 8'd1;
        n.s_chg    = m.chg_pend;
        n.chg_pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set = 1'b0;
            if (tick) begin
                if (m.sy2[i] != m.s[i]) begin
                    if (int'(m.run[i]) + 1 >= deb) begin
                        n.s[i]     = m.sy2[i];
                        n.run[i]   = 8'd0;
                        n.chat[i]  = 8'd0;
                        n.chg_pend = 1'b1;
                    end else begin
                        n.run[i] = m.run[i] + 8'd1;
                    end
                end else if (m.run[i] != 8'd0) begin
                    n.run[i]  = 8'd0;
                    n.chat[i] = (int'(m.chat[i]) < cm) ? m.chat[i] + 8'd1 : m.chat[i];
                    set       = (int'(n.chat[i]) == cm);
                end
            end
            if (set) begin
                n.flt[i] = 1'b1;
            end else if (clr) begin
                n.flt[i]  = 1'b0;
                n.chat[i] = 8'd0;
            end
        end
        n.sy2 = m.sy1;
        n.sy1 = r;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, raw, flt_clr, 4, 1, 8);
            mb <= mstep(mb, raw, flt_clr, 2, 3, 8);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("a_s",     32'(ifa.s),     32'(ma.s));
        chk("a_s_chg", 32'(ifa.s_chg), 32'(ma.s_chg));
        chk("a_flt",   32'(ifa.flt),   32'(ma.flt));
        chk("b_s",     32'(ifb.s),     32'(mb.s));
        chk("b_s_chg", 32'(ifb.s_chg), 32'(mb.s_chg));
        chk("b_flt",   32'(ifb.flt),   32'(mb.flt));
    end

    // Advance n clocks; inputs change well away from both clock edges
    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #5;
        end
    endtask

    initial begin
        // Reset with all lines high
        step_n(3);
        chk("rst_s",     32'(ifa.s),     32'h0);
        chk("rst_s_chg", 32'(ifa.s_chg), 32'h0);
        chk("rst_flt",   32'(ifa.flt),   32'h0);
        chk("rst_b_s",   32'(ifb.s),     32'h0);
        rst_n = 1'b1;
        step_n(5);
        chk("rel_s_e5",  32'(ifa.s), 32'h0);
        step_n(1);
        chk("rel_s_e6",  32'(ifa.s), 32'h3F);
        chk("rel_model", 32'(ma.s),  32'h3F);
        chk("rel_chg_e6", 32'(ifa.s_chg), 32'h0);
        step_n(1);
        chk("rel_chg_e7", 32'(ifa.s_chg), 32'h1);
        step_n(1);
        chk("rel_chg_e8", 32'(ifa.s_chg), 32'h0);

        // Clean step on the fall sensor
        raw = 6'h00;
        step_n(14);
        chk("step_base", 32'(ifa.s), 32'h0);
        raw = 6'b100000;
        step_n(5);
        chk("step_e4", 32'(ifa.s), 32'h0);
        step_n(1);
        chk("step_e5", 32'(ifa.s), 32'h20);
        chk("step_chg_e5", 32'(ifa.s_chg), 32'h0);
        step_n(1);
        chk("step_chg_e6", 32'(ifa.s_chg), 32'h1);

        // Short bounce on two channels
        raw = 6'h00;
        step_n(14);
        raw = 6'b000110;
        step_n(3);
        raw = 6'h00;
        for (int i = 0; i < 10; i++) begin
            step_n(1);
            chk("bounce_s",   32'(ifa.s),     32'h0);
            chk("bounce_chg", 32'(ifa.s_chg), 32'h0);
        end
        chk("bounce_flt", 32'(ifa.flt), 32'h0);

        // Chatter on channel 2; FLT_CLR coincides with the 8th bounce
        flt_clr = 1'b1;
        step_n(1);
        flt_clr = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == 7) chk("chat_pre_flt", 32'(ifa.flt), 32'h0);
            raw[2] = 1'b1;
            step_n(2);
            raw[2] = 1'b0;
            step_n(2);
        end
        flt_clr = 1'b1;
        step_n(1);
        flt_clr = 1'b0;
        chk("chat_flt_set", 32'(ifa.flt), 32'h04);
        chk("chat_s",       32'(ifa.s),   32'h0);
        step_n(3);
        chk("chat_flt_hold", 32'(ifa.flt), 32'h04);
        flt_clr = 1'b1;
        step_n(1);
        flt_clr = 1'b0;
        chk("chat_flt_clr", 32'(ifa.flt), 32'h0);

        // Reset in the middle of a debounce
        raw = 6'b001000;
        step_n(14);
        chk("mid_base", 32'(ifa.s), 32'h08);
        raw = 6'b001001;
        step_n(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s",   32'(ifa.s),     32'h0);
        chk("mid_rst_flt", 32'(ifa.flt),   32'h0);
        step_n(2);
        rst_n = 1'b1;
        step_n(5);
        chk("mid_e5", 32'(ifa.s), 32'h0);
        step_n(1);
        chk("mid_e6", 32'(ifa.s), 32'h09);

        // Prescaled instance: ticks on edges 1, 4, 7 after release
        rst_n = 1'b0;
        raw = 6'b000010;
        step_n(2);
        rst_n = 1'b1;
        step_n(4);
        chk("div_e4", 32'(ifb.s), 32'h0);
        step_n(2);
        chk("div_e6", 32'(ifb.s), 32'h0);
        step_n(1);
        chk("div_e7", 32'(ifb.s), 32'h02);
        chk("div_model", 32'(mb.s), 32'h02);
        step_n(1);
        chk("div_chg_e8", 32'(ifb.s_chg), 32'h1);

        // Randomised traffic: bit flips held for short or long runs,
        // occasional fault clears and resets
        for (int c = 0; c < 400; c++) begin
            int         hold;
            logic [5:0] flip;
            flip = 6'($urandom);
            if ($urandom_range(0, 3) == 0) flip = 6'h00;
            raw = raw ^ flip;
            hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(1, 12));
            for (int h = 0; h < hold; h++) begin
                flt_clr = ($urandom_range(0, 24) == 0);
                step_n(1);
            end
            flt_clr = 1'b0;
            if ($urandom_range(0, 80) == 0) begin
                rst_n = 1'b0;
                step_n(2);
                rst_n = 1'b1;
            end
        end
        step_n(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
